bcd_serial_subtractor: RTL and testbench

- Multi-digit packed-BCD subtractor computing diff = a - b.
- Digit-serial: one BCD digit per clock, least-significant digit first, with a borrow carried between digits.
- Subtraction counterpart of the combinational BCD adder stage; used in the BCD arithmetic datapath for decrement and compare operations.
- start/busy/done handshake toward the controlling logic.

---
 rtl/bcd_serial_subtractor.sv | 220 ++++++++++++++++++++++
 tb/tb_bcd_serial_subtractor.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor (diff = a - b), one digit per clock, LSD first.
// Optional sign-magnitude result: define BCD_SUB_SIGN_MAG_EN to add the NEG pass.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// SUB     | subtracting digit cnt of a - b, borrow rippling upward
// NEG     | (BCD_SUB_SIGN_MAG_EN) rewriting diff as 0 - diff for |a - b|
// DONE    | one-cycle done pulse; start here chains the next operation
module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] diff,
  output logic                borrow,
  output logic                err
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

`ifdef BCD_SUB_SIGN_MAG_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_NEG  = 2'd2,
    ST_DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_DONE = 2'd3
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             borrow_q, borrow_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [3:0]       a_dig, b_dig, old_dig;
  logic [3:0]       min_dig, sub_dig, res_dig;
  logic [4:0]       t;
  logic             brw_nxt;

  function automatic logic has_bad_nibble(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  always_comb begin
    a_dig   = 4'd0;
    b_dig   = 4'd0;
    old_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        a_dig   = a_q[4*i +: 4];
        b_dig   = b_q[4*i +: 4];
        old_dig = diff_q[4*i +: 4];
      end
    end

    // NEG reuses the digit datapath as 0 - diff
`ifdef BCD_SUB_SIGN_MAG_EN
    if (state_q == ST_NEG) begin
      min_dig = 4'd0;
      sub_dig = old_dig;
    end else begin
      min_dig = a_dig;
      sub_dig = b_dig;
    end
`else
    min_dig = a_dig;
    sub_dig = b_dig;
`endif

    t = {1'b0, min_dig} - {1'b0, sub_dig} - {4'b0000, brw_q};
    if (t[4]) begin
      res_dig = t[3:0] + 4'd10;
      brw_nxt = 1'b1;
    end else begin
      res_dig = t[3:0];
      brw_nxt = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    brw_d    = brw_q;
    borrow_d = borrow_q;
    err_d    = err_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          a_d      = a;
          b_d      = b;
          diff_d   = '0;
          cnt_d    = '0;
          brw_d    = 1'b0;
          borrow_d = 1'b0;
          err_d    = 1'b0;
          if (has_bad_nibble(a) || has_bad_nibble(b)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SUB;
            busy_d  = 1'b1;
          end
        end
      end

      ST_SUB: begin
        busy_d = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
          if (cnt_q == CNT_W'(i)) diff_d[4*i +: 4] = res_dig;
        end
        brw_d = brw_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_DIGIT) begin
          cnt_d    = '0;
          borrow_d = brw_nxt;
`ifdef BCD_SUB_SIGN_MAG_EN
          if (brw_nxt) begin
            state_d = ST_NEG;
            brw_d   = 1'b0;
          end else begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
`else
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end
      end

`ifdef BCD_SUB_SIGN_MAG_EN
      ST_NEG: begin
        busy_d = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
          if (cnt_q == CNT_W'(i)) diff_d[4*i +: 4] = res_dig;
        end
        brw_d = brw_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_DIGIT) begin
          cnt_d   = '0;
          brw_d   = 1'b0;
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      brw_q    <= 1'b0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      brw_q    <= brw_d;
      borrow_q <= borrow_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign err    = err_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed-vector bench for bcd_serial_subtractor (DIGITS=4); honours BCD_SUB_SIGN_MAG_EN.
module tb_bcd_serial_subtractor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        borrow;
  logic        err;

  int checks = 0;
  int errors = 0;

  bcd_serial_subtractor #(.DIGITS(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (op_a),
    .b      (op_b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_diff;
    logic        exp_borrow;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at the negedge after the acceptance edge; returns at the negedge where done is seen.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && lat < 50) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic launch(input logic [15:0] va, input logic [15:0] vb);
    start = 1'b1;
    op_a  = va;
    op_b  = vb;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int lat;
    int bc;
    int done_seen;

    vecs[0]  = '{16'h5432, 16'h1234, 16'h4198, 1'b0, 1'b0, 4};
    vecs[1]  = '{16'h0100, 16'h0001, 16'h0099, 1'b0, 1'b0, 4};
    vecs[2]  = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 4};
`ifdef BCD_SUB_SIGN_MAG_EN
    vecs[3]  = '{16'h1234, 16'h5432, 16'h4198, 1'b1, 1'b0, 8};
    vecs[6]  = '{16'h0000, 16'h0001, 16'h0001, 1'b1, 1'b0, 8};
`else
    vecs[3]  = '{16'h1234, 16'h5432, 16'h5802, 1'b1, 1'b0, 4};
    vecs[6]  = '{16'h0000, 16'h0001, 16'h9999, 1'b1, 1'b0, 4};
`endif
    vecs[4]  = '{16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, 0};
    vecs[5]  = '{16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, 4};
    vecs[7]  = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 4};
    vecs[8]  = '{16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 4};
    vecs[9]  = '{16'h0000, 16'h000F, 16'h0000, 1'b0, 1'b1, 0};
    vecs[10] = '{16'h9000, 16'h0999, 16'h8001, 1'b0, 1'b0, 4};

    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_diff",   32'(diff),   32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    check("rst_err",    32'(err),    32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      launch(vecs[i].a, vecs[i].b);
      wait_done(lat, bc);
      check($sformatf("v%0d_lat", i),    32'(lat),    32'(vecs[i].exp_lat));
      check($sformatf("v%0d_busycyc", i), 32'(bc),    32'(vecs[i].exp_lat));
      check($sformatf("v%0d_diff", i),   32'(diff),   32'(vecs[i].exp_diff));
      check($sformatf("v%0d_borrow", i), 32'(borrow), 32'(vecs[i].exp_borrow));
      check($sformatf("v%0d_err", i),    32'(err),    32'(vecs[i].exp_err));
      check($sformatf("v%0d_busy_in_done", i), 32'(busy), 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      check($sformatf("v%0d_diff_hold", i),  32'(diff), 32'(vecs[i].exp_diff));
    end

    // start re-pulsed during SUB must be ignored
    launch(16'h5432, 16'h1234);
    start = 1'b1;
    op_a  = 16'h9999;
    op_b  = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    check("ignore_lat",  32'(lat),    32'd3);
    check("ignore_diff", 32'(diff),   32'h4198);
    check("ignore_brw",  32'(borrow), 32'd0);
    @(negedge clk);

    // start held in the DONE cycle chains a second operation
    launch(16'h0100, 16'h0001);
    wait_done(lat, bc);
    check("b2b_first_diff", 32'(diff), 32'h0099);
    start = 1'b1;
    op_a  = 16'h0005;
    op_b  = 16'h0002;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done(lat, bc);
    check("b2b_lat",  32'(lat),  32'd4);
    check("b2b_diff", 32'(diff), 32'h0003);
    check("b2b_brw",  32'(borrow), 32'd0);
    @(negedge clk);

    // reset in the middle of SUB discards everything
    launch(16'h9999, 16'h1111);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy",   32'(busy),   32'd0);
    check("midrst_done",   32'(done),   32'd0);
    check("midrst_diff",   32'(diff),   32'd0);
    check("midrst_borrow", 32'(borrow), 32'd0);
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    check("midrst_no_done", 32'(done_seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
